sar_ctrl_param: RTL and testbench



---
 rtl/sar_ctrl_param.sv | 209 ++++++++++++++++++++
 tb/tb_sar_ctrl_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_ctrl_param.sv
// sar_ctrl_param: parametrised successive-approximation ADC controller.
// Drives the sample switch and the DAC trial code, collects comparator decisions
// MSB first, and holds the last completed conversion in result.
//
// Build option: define SAR_AVG_EN so that one accepted start runs 2**AVG_LOG2
// conversions back to back. Their sum is accumulated and result gets the
// truncated mean. Without SAR_AVG_EN each start runs one conversion, AVG_LOG2 is
// only range-checked, and no accumulator is built.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | waiting for start; sample=0, dac_code=0, busy=0
// S_SAMPLE | sample switch closed for SAMPLE_CYCLES cycles
// S_SETTLE | DAC settling on the current trial code for SETTLE_CYCLES cycles
// S_DECIDE | comparator sampled at the end of this cycle; bit idx resolved
module sar_ctrl_param #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int AVG_LOG2      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Bad parameter values stop elaboration instead of building a broken counter.
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("sar_ctrl_param: WIDTH must be 2..16");
    end
    if (SAMPLE_CYCLES < 1) begin : g_bad_sample
        $error("sar_ctrl_param: SAMPLE_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 0) begin : g_bad_settle
        $error("sar_ctrl_param: SETTLE_CYCLES must be >= 0");
    end
    if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_avg
        $error("sar_ctrl_param: AVG_LOG2 must be 1..4");
    end

    localparam int IDX_W   = $clog2(WIDTH);
    localparam int TMR_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TOP_MASK    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [TMR_W-1:0] SAMPLE_LOAD = TMR_W'(SAMPLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_SETTLE = 2'd2,
        S_DECIDE = 2'd3
    } state_t;

    // With no settle time the trial code is decided in the cycle it is applied.
    localparam state_t S_TRIAL = (SETTLE_CYCLES == 0) ? S_DECIDE : S_SETTLE;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] tmr;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] next_mask;
    logic [WIDTH-1:0] decided;

`ifdef SAR_AVG_EN
    localparam int ACC_W = WIDTH + AVG_LOG2;

    logic [AVG_LOG2-1:0] conv_cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [WIDTH-1:0]    avg_result;

    // Running sum including the conversion that is finishing this cycle.
    always_comb begin
        acc_sum    = acc + ACC_W'(decided);
        avg_result = WIDTH'(acc_sum >> AVG_LOG2);
    end
`endif

    // dac_code holds the decided upper bits plus the trial bit at idx;
    // a 0 from the comparator simply clears the trial bit.
    always_comb begin
        bit_mask  = WIDTH'(1) << idx;
        next_mask = WIDTH'(1) << (idx - IDX_W'(1));
        decided   = cmp ? dac_code : (dac_code & ~bit_mask);
    end

    // Sequencer: phase timing, bit-by-bit decisions, result capture and handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            tmr      <= '0;
            sample   <= 1'b0;
            dac_code <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
`ifdef SAR_AVG_EN
            conv_cnt <= '0;
            acc      <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && abort) begin
                // Drop the conversion in flight; result keeps the previous value.
                state    <= S_IDLE;
                idx      <= '0;
                tmr      <= '0;
                sample   <= 1'b0;
                dac_code <= '0;
                busy     <= 1'b0;
`ifdef SAR_AVG_EN
                conv_cnt <= '0;
                acc      <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_SAMPLE;
                            sample   <= 1'b1;
                            busy     <= 1'b1;
                            tmr      <= SAMPLE_LOAD;
                            idx      <= IDX_TOP;
                            dac_code <= '0;
`ifdef SAR_AVG_EN
                            conv_cnt <= '0;
                            acc      <= '0;
`endif
                        end
                    end

                    S_SAMPLE: begin
                        if (tmr == '0) begin
                            state    <= S_TRIAL;
                            sample   <= 1'b0;
                            dac_code <= TOP_MASK;
                            tmr      <= SETTLE_LOAD;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end

                    S_SETTLE: begin
                        if (tmr == '0) begin
                            state <= S_DECIDE;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end

                    S_DECIDE: begin
                        if (idx != '0) begin
                            state    <= S_TRIAL;
                            idx      <= idx - IDX_W'(1);
                            dac_code <= decided | next_mask;
                            tmr      <= SETTLE_LOAD;
`ifdef SAR_AVG_EN
                        end else if (conv_cnt != '1) begin
                            // Next conversion of the batch starts with a fresh sample.
                            state    <= S_SAMPLE;
                            conv_cnt <= conv_cnt + AVG_LOG2'(1);
                            acc      <= acc_sum;
                            sample   <= 1'b1;
                            tmr      <= SAMPLE_LOAD;
                            idx      <= IDX_TOP;
                            dac_code <= '0;
                        end else begin
                            state    <= S_IDLE;
                            result   <= avg_result;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            dac_code <= '0;
                            idx      <= '0;
                            conv_cnt <= '0;
                            acc      <= '0;
                        end
`else
                        end else begin
                            state    <= S_IDLE;
                            result   <= decided;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            dac_code <= '0;
                            idx      <= '0;
                        end
`endif
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_ctrl_param.sv
// Bench for sar_ctrl_param with default parameters (WIDTH=8, SAMPLE_CYCLES=2,
// SETTLE_CYCLES=1). The comparator is modelled as cmp = (vin >= dac_code).
// Cycle k is the interval after the k-th clock edge that follows the edge
// that sampled start. Conversion results are queued when start is driven and
// checked when done shows up.
module tb_sar_ctrl_param;

    localparam int W    = 8;
    localparam int CONV = 18;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         cmp;
    logic [W-1:0] vin   = '0;

    logic         sample;
    logic [W-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    assign cmp = (vin >= dac_code);

    always #5 clk = ~clk;

    sar_ctrl_param #(
        .WIDTH(W),
        .SAMPLE_CYCLES(2),
        .SETTLE_CYCLES(1),
        .AVG_LOG2(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .cmp(cmp),
        .sample(sample),
        .dac_code(dac_code),
        .busy(busy),
        .done(done),
        .result(result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            check("done_has_expect", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("sb_result", result, mon_exp);
            end
        end
    end

    // Drive start for one edge; returns in cycle 0 of the conversion.
    task automatic launch(input logic [W-1:0] v, input bit push);
        vin = v;
        if (push) exp_q.push_back(v);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Follow one conversion from cycle 0 to the done cycle, checking phases and
    // every trial code against a bit-serial reference. poke_k pulses start once
    // mid-conversion; hold keeps start high so it is still high in the done cycle.
    task automatic track(input logic [W-1:0] v, input int poke_k, input bit hold);
        logic [W-1:0] code_m;
        logic [W-1:0] trial;
        int b;
        code_m = '0;
        if (hold) start = 1'b1;
        for (int k = 0; k < CONV; k++) begin
            check("busy", busy, 1);
            check("sample", 32'(k < 2), 32'(sample));
            check("no_early_done", done, 0);
            if (k >= 2) begin
                b     = 7 - (k - 2) / 2;
                trial = code_m | (W'(1) << b);
                check("dac_trial", dac_code, trial);
                if ((k - 2) % 2 == 1 && v >= trial) code_m = trial;
            end else begin
                check("dac_in_sample", dac_code, 0);
            end
            if (k == poke_k) start = 1'b1;
            tick();
            if (k == poke_k && !hold) start = 1'b0;
        end
        check("done_at_18", done, 1);
        check("busy_low_at_done", busy, 0);
        check("result_model", result, code_m);
        check("result_vin", result, v);
    endtask

    initial begin
        int dc0;

        repeat (3) tick();
        check("rst_sample", sample, 0);
        check("rst_dac", dac_code, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        tick();

`ifdef SAR_AVG_EN
        // Four conversions of 0x10..0x13 averaged to 0x11.
        exp_q.push_back(8'h11);
        vin   = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4 * CONV; k++) begin
            if (k % CONV == 0) vin = W'(8'h10 + k / CONV);
            check("avg_busy", busy, 1);
            check("avg_no_done", done, 0);
            check("avg_sample", 32'((k % CONV) < 2), 32'(sample));
            tick();
        end
        check("avg_done_72", done, 1);
        check("avg_result", result, 8'h11);
        tick();
        check("avg_single_done", done, 0);
`else
        // Tracking conversion with the reference trial sequence.
        launch(8'hA5, 1);
        track(8'hA5, -1, 0);
        check("result_a5", result, 8'hA5);
        tick();
        check("done_one_cycle", done, 0);

        // Extremes.
        launch(8'h00, 1);
        track(8'h00, -1, 0);
        launch(8'hFF, 1);
        track(8'hFF, -1, 0);

        // start while busy is ignored.
        tick();
        dc0 = done_cnt;
        launch(8'h5A, 1);
        track(8'h5A, 5, 0);
        repeat (25) tick();
        check("busy_start_ignored", busy, 0);
        check("one_done", done_cnt, dc0 + 1);

        // start held through the done cycle chains a second conversion.
        launch(8'h33, 1);
        track(8'h33, -1, 1);
        exp_q.push_back(8'hC7);
        vin = 8'hC7;
        tick();
        start = 1'b0;
        check("b2b_sample", sample, 1);
        check("b2b_busy", busy, 1);
        track(8'hC7, -1, 0);

        // Abort during the bit-3 decision.
        launch(8'hA5, 1);
        track(8'hA5, -1, 0);
        tick();
        dc0 = done_cnt;
        launch(8'h3C, 0);
        repeat (11) tick();
        check("abort_pre_dac", dac_code, 8'h38);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_sample", sample, 0);
        check("abort_dac", dac_code, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 8'hA5);
        repeat (25) tick();
        check("abort_no_done", done_cnt, dc0);
        check("abort_result_held", result, 8'hA5);

        // Reset at cycle 7, then a normal conversion.
        launch(8'h77, 0);
        repeat (7) tick();
        reset = 1'b1;
        tick();
        check("mrst_sample", sample, 0);
        check("mrst_dac", dac_code, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_result", result, 0);
        reset = 1'b0;
        launch(8'h2B, 1);
        track(8'h2B, -1, 0);
`endif

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
